// File: rtl/cond_event_arbiter_pkg.sv
// Shared types and helpers for the condition/event arbiter.
// Optional build switch: COND_EVT_DROP_COUNT_EN.
package cond_evt_pkg;

  localparam logic EVT_FALL = 1'b0;
  localparam logic EVT_RISE = 1'b1;

  // Wide enough for the largest supported channel count (32).
  localparam int CH_MAX_W = 5;

  typedef struct packed {
    logic [CH_MAX_W-1:0] ch;
    logic                rise;
  } evt_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ost_e;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input int unsigned w
  );
    logic [32:0] lim;
    logic [32:0] sum;
    lim = (33'd1 << w) - 33'd1;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int unsigned w
  );
    return sat_add(v, 32'd1, w);
  endfunction

endpackage

// File: rtl/cond_event_arbiter_if.sv
// Event stream handshake bundle between arbiter and consumer.
// Optional build switch: COND_EVT_DROP_COUNT_EN (not used here).
interface cond_evt_if #(
  parameter int NCH = 4
) ();

  localparam int CHW = $clog2(NCH);

  logic           evt_valid_o;
  logic           evt_ready_i;
  logic [CHW-1:0] evt_ch_o;
  logic           evt_rise_o;

  modport master (
    output evt_valid_o,
    output evt_ch_o,
    output evt_rise_o,
    input  evt_ready_i
  );

  modport slave (
    input  evt_valid_o,
    input  evt_ch_o,
    input  evt_rise_o,
    output evt_ready_i
  );

endinterface

// File: rtl/cond_event_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr.
// Optional build switch: COND_EVT_DROP_COUNT_EN (not used here).
module rr_arbiter #(
  parameter  int NCH = 4,
  localparam int CHW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [CHW-1:0] ptr_i,
  output logic [NCH-1:0] gnt_oh_o,
  output logic [CHW-1:0] gnt_idx_o,
  output logic           any_o
);

  int j;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    j         = 0;
    for (int i = 0; i < NCH; i++) begin
      j = int'(ptr_i) + i;
      if (j >= NCH) j = j - NCH;
      if (!any_o && req_i[CHW'(j)]) begin
        any_o               = 1'b1;
        gnt_idx_o           = CHW'(j);
        gnt_oh_o[CHW'(j)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cond_event_arbiter.sv
// Edge monitor with per-channel pending slot and round-robin event output.
// Optional build switch: COND_EVT_DROP_COUNT_EN adds drop_cnt_o.
module cond_event_arbiter
  import cond_evt_pkg::*;
#(
  parameter  int NCH   = 4,
  parameter  int CNT_W = 8,
  localparam int CHW   = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   cond_i,
  cond_evt_if.master       evt,
  output logic [NCH-1:0]   pend_o,
  output logic [NCH-1:0]   ovf_o,
  input  logic [CHW-1:0]   cnt_sel_i,
  output logic [CNT_W-1:0] cnt_o,
  input  logic             clr_i
`ifdef COND_EVT_DROP_COUNT_EN
  ,
  output logic [CNT_W-1:0] drop_cnt_o
`endif
);

  logic [NCH-1:0]   cond_q;
  logic [NCH-1:0]   pend_q, pend_d;
  logic [NCH-1:0]   type_q, type_d;
  logic [NCH-1:0]   ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [CHW-1:0]   ptr_q, ptr_d;
  ost_e             state_q, state_d;
  evt_t             out_q, out_d;

  logic [NCH-1:0]   edge_v;
  logic [NCH-1:0]   gnt_oh;
  logic [CHW-1:0]   gnt_idx;
  logic             gnt_any;
  logic             load, take, hs;
  logic [NCH-1:0]   clr_v, drop_v, store_v;

  rr_arbiter #(
    .NCH (NCH)
  ) u_rr (
    .req_i     (pend_q),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  assign edge_v = cond_i ^ cond_q;
  assign load   = (state_q == ST_EMPTY) || evt.evt_ready_i;
  assign take   = load && gnt_any;
  assign hs     = (state_q == ST_FULL) && evt.evt_ready_i;

  // A grant frees the slot this cycle, so a same-cycle edge is kept.
  assign clr_v   = take ? gnt_oh : '0;
  assign drop_v  = edge_v & pend_q & ~clr_v;
  assign store_v = edge_v & ~drop_v;

  always_comb begin
    pend_d = (pend_q & ~clr_v) | store_v;
    type_d = (type_q & ~store_v) | (cond_i & store_v);
    ovf_d  = clr_i ? '0 : (ovf_q | drop_v);
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (take) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (evt.evt_ready_i && !gnt_any) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (take) begin
      out_d.ch   = CH_MAX_W'(gnt_idx);
      out_d.rise = type_q[gnt_idx];
      ptr_d      = (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      cnt_d[c] = cnt_q[c];
      if (clr_i) begin
        cnt_d[c] = '0;
      end else if (hs && int'(out_q.ch) == c) begin
        cnt_d[c] = CNT_W'(sat_inc(32'(cnt_q[c]), CNT_W));
      end
    end
  end

`ifdef COND_EVT_DROP_COUNT_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = clr_i ? '0 :
      CNT_W'(sat_add(32'(drop_cnt_q), 32'($countones(drop_v)), CNT_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_q  <= '0;
      pend_q  <= '0;
      type_q  <= '0;
      ovf_q   <= '0;
      ptr_q   <= '0;
      state_q <= ST_EMPTY;
      out_q   <= '0;
      for (int c = 0; c < NCH; c++) cnt_q[c] <= '0;
    end else begin
      cond_q  <= cond_i;
      pend_q  <= pend_d;
      type_q  <= type_d;
      ovf_q   <= ovf_d;
      ptr_q   <= ptr_d;
      state_q <= state_d;
      out_q   <= out_d;
      for (int c = 0; c < NCH; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  always_comb begin
    cnt_o = '0;
    if (int'(cnt_sel_i) < NCH) cnt_o = cnt_q[cnt_sel_i];
  end

  assign evt.evt_valid_o = (state_q == ST_FULL);
  assign evt.evt_ch_o    = out_q.ch[CHW-1:0];
  assign evt.evt_rise_o  = out_q.rise;
  assign pend_o          = pend_q;
  assign ovf_o           = ovf_q;

endmodule

// File: tb/tb_cond_event_arbiter.sv
// Directed + random bench for cond_event_arbiter with a queue-free model.
// Optional build switch: COND_EVT_DROP_COUNT_EN checks drop_cnt_o too.
module tb_cond_event_arbiter;
  import cond_evt_pkg::*;

  localparam int NCH   = 4;
  localparam int CNT_W = 8;
  localparam int CHW   = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NCH-1:0]   cond_i = '0;
  logic [NCH-1:0]   pend_o, ovf_o;
  logic [CHW-1:0]   cnt_sel_i = '0;
  logic [CNT_W-1:0] cnt_o;
  logic             clr_i = 1'b0;
`ifdef COND_EVT_DROP_COUNT_EN
  logic [CNT_W-1:0] drop_cnt_o;
`endif

  cond_evt_if #(.NCH(NCH)) evt ();

  cond_event_arbiter #(
    .NCH   (NCH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cond_i    (cond_i),
    .evt       (evt),
    .pend_o    (pend_o),
    .ovf_o     (ovf_o),
    .cnt_sel_i (cnt_sel_i),
    .cnt_o     (cnt_o),
    .clr_i     (clr_i)
`ifdef COND_EVT_DROP_COUNT_EN
    ,
    .drop_cnt_o (drop_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: pending slot per channel plus one output register.
  int m_pend [NCH];
  int m_typ  [NCH];
  int m_ovf  [NCH];
  int m_cnt  [NCH];
  int m_cond [NCH];
  int m_v, m_ch, m_rise, m_ptr, m_dcnt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_pend[c] = 0; m_typ[c] = 0; m_ovf[c] = 0;
      m_cnt[c] = 0;  m_cond[c] = 0;
    end
    m_v = 0; m_ch = 0; m_rise = 0; m_ptr = 0; m_dcnt = 0;
  endtask

  task automatic model_step();
    int  g, nrise, drops;
    bit  ld, hs;
    ld = (m_v == 0) || evt.evt_ready_i;
    hs = (m_v != 0) && evt.evt_ready_i;
    g = -1;
    nrise = 0;
    if (ld) begin
      for (int i = 0; i < NCH; i++) begin
        int k;
        k = (m_ptr + i) % NCH;
        if (g < 0 && m_pend[k] != 0) g = k;
      end
    end
    if (g >= 0) begin
      nrise = m_typ[g];
      m_pend[g] = 0;
    end
    drops = 0;
    for (int c = 0; c < NCH; c++) begin
      if (int'(cond_i[c]) != m_cond[c]) begin
        if (m_pend[c] != 0) begin
          drops++;
          if (!clr_i) m_ovf[c] = 1;
        end else begin
          m_pend[c] = 1;
          m_typ[c]  = int'(cond_i[c]);
        end
      end
      m_cond[c] = int'(cond_i[c]);
    end
    if (clr_i) begin
      for (int c = 0; c < NCH; c++) begin
        m_ovf[c] = 0;
        m_cnt[c] = 0;
      end
      m_dcnt = 0;
    end else begin
      if (hs && m_cnt[m_ch] < CMAX) m_cnt[m_ch]++;
      m_dcnt = (m_dcnt + drops > CMAX) ? CMAX : m_dcnt + drops;
    end
    if (ld) begin
      if (g >= 0) begin
        m_v = 1; m_ch = g; m_rise = nrise;
        m_ptr = (g + 1) % NCH;
      end else begin
        m_v = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0] ep, eo;
    for (int c = 0; c < NCH; c++) begin
      ep[c] = m_pend[c][0];
      eo[c] = m_ovf[c][0];
    end
    chk("valid", 32'(evt.evt_valid_o), 32'(m_v));
    if (m_v != 0) begin
      chk("ch", 32'(evt.evt_ch_o), 32'(m_ch));
      chk("rise", 32'(evt.evt_rise_o), 32'(m_rise));
    end
    chk("pend", 32'(pend_o), 32'(ep));
    chk("ovf", 32'(ovf_o), 32'(eo));
`ifdef COND_EVT_DROP_COUNT_EN
    chk("drop_cnt", 32'(drop_cnt_o), 32'(m_dcnt));
`endif
    for (int s = 0; s < NCH; s++) begin
      cnt_sel_i = CHW'(s);
      #1;
      chk("cnt", 32'(cnt_o), 32'(m_cnt[s]));
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic cnt_is(input int s, input int exp, input string tag);
    cnt_sel_i = CHW'(s);
    #1;
    chk(tag, 32'(cnt_o), 32'(exp));
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_valid"}, 32'(evt.evt_valid_o), 32'd0);
    chk({tag, "_ch"}, 32'(evt.evt_ch_o), 32'd0);
    chk({tag, "_rise"}, 32'(evt.evt_rise_o), 32'd0);
    chk({tag, "_pend"}, 32'(pend_o), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf_o), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    zero_outputs("rst");
    cnt_is(0, 0, "rst_cnt");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    evt.evt_ready_i = 1'b1;
    model_reset();

    // Reset with idle inputs.
    #3;
    zero_outputs("init");
    cnt_is(2, 0, "init_cnt");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    chk("idle_valid", 32'(evt.evt_valid_o), 32'd0);

    // Single channel rise then fall.
    cond_i[2] = 1'b1;
    cycle();
    chk("ch2_pend", 32'(pend_o[2]), 32'd1);
    chk("ch2_not_yet", 32'(evt.evt_valid_o), 32'd0);
    cycle();
    chk("ch2_rise_v", 32'(evt.evt_valid_o), 32'd1);
    chk("ch2_rise_ch", 32'(evt.evt_ch_o), 32'd2);
    chk("ch2_rise_t", 32'(evt.evt_rise_o), 32'(EVT_RISE));
    cond_i[2] = 1'b0;
    cycle();
    cycle();
    chk("ch2_fall_ch", 32'(evt.evt_ch_o), 32'd2);
    chk("ch2_fall_t", 32'(evt.evt_rise_o), 32'(EVT_FALL));
    cycle();
    cnt_is(2, 2, "ch2_cnt");

    // All channels at once, pointer at 0.
    do_reset();
    cond_i = 4'b1111;
    cycle();
    for (int k = 0; k < NCH; k++) begin
      cycle();
      chk("burst_ch", 32'(evt.evt_ch_o), 32'(k));
    end
    cycle();
    chk("burst_end", 32'(evt.evt_valid_o), 32'd0);
    for (int k = 0; k < NCH; k++) cnt_is(k, 1, "burst_cnt");

    // Overflow while the output stage is stalled.
    cond_i = 4'b0000;
    for (int i = 0; i < 7; i++) cycle();
    evt.evt_ready_i = 1'b0;
    cond_i[0] = 1'b1;
    cycle();
    cycle();
    cond_i[1] = 1'b1;
    cycle();
    cond_i[1] = 1'b0;
    cycle();
    chk("ovf1", 32'(ovf_o[1]), 32'd1);
    evt.evt_ready_i = 1'b1;
    cycle();
    chk("ovf_ev_ch", 32'(evt.evt_ch_o), 32'd1);
    chk("ovf_ev_t", 32'(evt.evt_rise_o), 32'd1);
    cycle();
    cond_i[1] = 1'b1;
    cycle();
    cycle();
    chk("post_ovf_ch", 32'(evt.evt_ch_o), 32'd1);

    // Counter saturation and clear-over-increment.
    for (int i = 0; i < 300; i++) begin
      cond_i[0] = ~cond_i[0];
      cycle();
    end
    for (int i = 0; i < 3; i++) cycle();
    cnt_is(0, CMAX, "sat_cnt");
    cond_i[0] = ~cond_i[0];
    cycle();
    cycle();
    chk("clr_hs_v", 32'(evt.evt_valid_o), 32'd1);
    clr_i = 1'b1;
    cycle();
    clr_i = 1'b0;
    cnt_is(0, 0, "clr_cnt");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(3) == 0) cond_i[c] = ~cond_i[c];
      evt.evt_ready_i = ($urandom_range(3) != 0);
      clr_i = ($urandom_range(31) == 0);
      cycle();
    end
    clr_i = 1'b0;

    // Asynchronous reset with a stalled event in flight.
    evt.evt_ready_i = 1'b0;
    cond_i[3] = ~cond_i[3];
    cycle();
    cycle();
    cycle();
    cond_i = 4'b1010;
    do_reset();
    evt.evt_ready_i = 1'b1;
    cycle();
    cycle();
    chk("rel_ch_a", 32'(evt.evt_ch_o), 32'd1);
    cycle();
    chk("rel_ch_b", 32'(evt.evt_ch_o), 32'd3);
    for (int i = 0; i < 3; i++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_event_arbiter.md
Name: cond_event_arbiter

Overview:
- Parametrised multi-channel condition monitor and event arbiter.
- Each of NCH condition inputs is watched for rising and falling edges (the "if / else" outcomes). Detected edges are queued one per channel.
- Queued edges are serialised round-robin onto a single valid/ready event stream.
- Per-channel saturating counters record delivered events. The block sits between condition-producing logic and an event consumer/logger.

Parameters:
- NCH, 4, number of condition channels (2..32).
- CNT_W, 8, width of each per-channel delivered-event counter.
- CHW, $clog2(NCH), width of channel index (derived, not overridable).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cond_i  in  NCH  per-channel condition level, synchronous to clk.
- evt_valid_o  out  1  event available.
- evt_ready_i  in  1  consumer accepts event when high with evt_valid_o.
- evt_ch_o  out  CHW  channel index of presented event.
- evt_rise_o  out  1  1 = rising edge (then-branch), 0 = falling edge (else-branch).
- pend_o  out  NCH  per-channel pending flag.
- ovf_o  out  NCH  sticky per-channel overflow (edge lost).
- cnt_sel_i  in  CHW  counter read select.
- cnt_o  out  CNT_W  delivered-event count of channel cnt_sel_i (combinational mux of registers).
- clr_i  in  1  synchronous clear of all counters and ovf_o.

Behaviour:
- Reset values:
  - All outputs, cond_q, pending/type flags, ovf and counters are 0.
  - The round-robin pointer is 0.
  - A channel with cond_i=1 at reset release therefore generates one rise event.
- Edge detect: edge[c] = cond_i[c] ^ cond_q[c]; type = cond_i[c]. cond_q <= cond_i every cycle.
- Pending: on edge[c] the pending flag is set and the type is stored at the same clock edge.
- Edge while pending:
  - If the channel is not being granted that cycle, the new edge is dropped, the stored type is kept, and ovf_o[c] is set.
  - If the channel is granted that cycle, the new edge is stored (set wins over clear) and no overflow is flagged.
- Output stage:
  - The register loads when !evt_valid_o || evt_ready_i.
  - Grant = first pending channel at or after ptr, wrapping modulo NCH.
  - On load with any pending: evt_valid_o=1, ch/type are loaded, that channel's pending flag is cleared, and ptr <= grant+1 (wrapping NCH-1 -> 0).
  - On load with none pending: evt_valid_o=0.
  - While valid && !ready, ch and type are held stable.
- Latency: an edge present on cond_i before clock edge k sets pending at k, and evt_valid_o is asserted after k+1 if the output stage is free. Sustained throughput is 1 event/cycle with ready held high.
- Output FSM: EMPTY (valid=0) -> FULL on grant. FULL stays FULL on ready with another pending channel, returns to EMPTY on ready with none pending, and holds on !ready.
- Counters:
  - Increment on handshake (valid && ready) for evt_ch_o.
  - Saturate at 2^CNT_W-1.
  - clr_i and an increment in the same cycle: clear wins, result 0.
  - clr_i does not affect pending flags or the output stage.
- Reset mid-operation: asynchronous. The output drops immediately and the in-flight event is lost and not counted.

Optional Feature:
- Macro COND_EVT_DROP_COUNT_EN.
- When defined:
  - Adds output drop_cnt_o [CNT_W] counting total dropped edges across all channels, saturating.
  - Cleared by clr_i and by reset.
  - Multiple channels dropping in the same cycle add their popcount, saturating.
- When undefined: the port and its logic are absent; ovf_o behaviour is unchanged.

Decomposition:
- Package cond_evt_pkg:
  - EVT_FALL=1'b0 and EVT_RISE=1'b1 constants.
  - Event struct {ch, rise}.
  - Saturating-increment function parameterised by width.
- One sub-module, rr_arbiter (NCH): req vector and ptr in, one-hot grant, grant index and any_grant out; purely combinational.

Test Plan:
- Reset, cond_i=4'b0000 held, ready=1 -> evt_valid_o stays 0, all counters 0, pend_o=0.
- ch2 0->1 at cycle 5, ready=1 -> pend_o[2] high at edge 5, event {ch=2, rise=1} valid after edge 6; then 1->0 -> {2, rise=0}; cnt_o(sel=2)=2.
- cond_i 0000->1111 in one cycle, ready=1, ptr=0 -> four consecutive events ch 0,1,2,3, then valid=0; each counter =1.
- ready=0, ch1 toggles 0->1->0 on consecutive cycles -> only rise retained, ovf_o[1]=1; after ready -> {1, rise}, later edges delivered normally.
- Force 300 handshakes on ch0 with CNT_W=8 -> cnt_o saturates at 255; clr_i coinciding with a handshake -> 0.
- rst_n low while evt_valid_o=1 and ready=0 -> outputs 0 immediately; after release, current cond_i=1 channels produce rise events.
